// File: rtl/alu_sub_sequencer_if.sv
// alu_sub_sequencer_if: two requester channels plus the result channel of the nibble-serial subtractor.
interface alu_sub_sequencer_if #(parameter int NIB = 4);
    localparam int W = 4 * NIB;
    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_diff;
    logic         res_borrow;
    logic         res_zero;
    logic         res_id;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_diff, res_borrow, res_zero, res_id
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_diff, res_borrow, res_zero, res_id
    );
endinterface

// File: rtl/alu_sub_sequencer.sv
// alu_sub_sequencer: round-robin arbitrated A-B subtractor, one nibble per cycle through a shared 4-bit slice.
module alu_sub_sequencer #(parameter int NIB = 4) (
    input logic clk,
    input logic rst_n,
    alu_sub_sequencer_if.slave bus
);
    localparam int W = 4 * NIB;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]   state;
    logic [W-1:0] a_r, b_r, diff;
    logic         borrow, id, last_grant;
    logic [2:0]   idx;
    logic         g0, g1;
    logic [4:0]   slice;
    always_comb begin
        g0 = rst_n && state == IDLE && bus.req0_valid && (!bus.req1_valid || last_grant);
        g1 = rst_n && state == IDLE && bus.req1_valid && (!bus.req0_valid || !last_grant);
        slice = {1'b0, a_r[idx*4 +: 4]} - {1'b0, b_r[idx*4 +: 4]} - {4'd0, borrow};
    end
    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    assign bus.res_valid  = state == DONE;
    assign bus.res_diff   = diff;
    assign bus.res_borrow = borrow;
    assign bus.res_zero   = diff == '0;
    assign bus.res_id     = id;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            diff       <= '0;
            borrow     <= 1'b0;
            id         <= 1'b0;
            idx        <= '0;
            last_grant <= 1'b1;
        end else if (state == IDLE) begin
            if (g0 || g1) begin
                a_r        <= g1 ? bus.req1_a : bus.req0_a;
                b_r        <= g1 ? bus.req1_b : bus.req0_b;
                id         <= g1;
                last_grant <= g1;
                idx        <= '0;
                borrow     <= 1'b0;
                state      <= RUN;
            end
        end else if (state == RUN) begin
            // slice[4] is the borrow-out: the 5-bit difference goes negative exactly when a_i < b_i + bin
            diff[idx*4 +: 4] <= slice[3:0];
            borrow           <= slice[4];
            idx              <= idx + 3'd1;
            if (idx == 3'(NIB - 1))
                state <= DONE;
        end else if (bus.res_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: doc/alu_sub_sequencer.md
ALU_SUB_SEQUENCER -- requirements
Module: alu_sub_sequencer

Interface
REQ-001 Parameter NIB, default 4, legal 1..8: number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low, sampled on rising clk.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_a  in  W  requester 0 minuend A.
REQ-006 req0_b  in  W  requester 0 subtrahend B.
REQ-007 req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-008 req1_valid / req1_a / req1_b / req1_ready: same directions, widths and meanings for requester 1.
REQ-009 res_valid  out  1  result available.
REQ-010 res_ready  in  1  consumer takes result.
REQ-011 res_diff  out  W  A - B modulo 2^W.
REQ-012 res_borrow  out  1  final borrow-out; 1 iff A < B unsigned.
REQ-013 res_zero  out  1  1 iff res_diff == 0.
REQ-014 res_id  out  1  index of requester that issued the result.

Function
REQ-015 FSM states IDLE, RUN, DONE; only one operation in flight.
REQ-016 IDLE: arbiter grants exactly one valid requester; ready asserted combinationally to granted requester only; other ready low.
REQ-017 Arbitration round-robin: both valid -> grant requester not granted last; one valid -> grant it; last_grant resets to 1 (req0 wins first tie).
REQ-018 Handshake req_valid && req_ready at edge: capture A, B, id into registers, update last_grant, nibble index = 0, borrow = 0, go RUN.
REQ-019 RUN and DONE: req0_ready = req1_ready = 0 regardless of valids.
REQ-020 RUN: one nibble per cycle, LSB nibble first, through a single shared 4-bit slice: d = (a_i - b_i - bin) mod 16; bout = 1 iff a_i < b_i + bin (borrow-out of 4-bit subtractor).
REQ-021 RUN: d written into nibble i of diff register; borrow register <= bout; index increments; after nibble NIB-1 processed, go DONE.
REQ-022 Latency: operation accepted at edge k -> res_valid high in the cycle following edge k+NIB.
REQ-023 DONE: res_valid = 1; res_diff, res_borrow, res_zero, res_id held stable while res_ready low.
REQ-024 res_valid && res_ready at edge -> IDLE; no new operation accepted in that same cycle (next accept earliest one cycle later).
REQ-025 res_zero derived from full diff register; res_valid low in IDLE and RUN; res_diff may change during RUN.
REQ-026 Requester dropping valid before grant: no effect; operands sampled only at handshake edge.
REQ-027 NIB = 1: single RUN cycle; behaviour equals the 4-bit subtractor plus registers.

Reset
REQ-028 rst_n low at edge: state IDLE, diff = 0, borrow = 0, id = 0, index = 0, last_grant = 1, regardless of current state.
REQ-029 During reset and cycle after: res_valid = 0, res_diff = 0, res_borrow = 0, res_zero = 1, res_id = 0, req0_ready = req1_ready = 0 while rst_n low.
REQ-030 Reset mid-RUN or mid-DONE: operation discarded, no result produced afterward.

Verification (NIB = 4)
REQ-031 req0 A=0x1234, B=0x0234 -> 4 cycles later res_diff=0x1000, res_borrow=0, res_zero=0, res_id=0.
REQ-032 req1 A=0x0000, B=0x0001 -> res_diff=0xFFFF, res_borrow=1, res_zero=0, res_id=1; borrow ripples through all 4 nibbles.
REQ-033 req0 A=B=0xA5A5 -> res_diff=0x0000, res_zero=1, res_borrow=0.
REQ-034 Both valid from reset (req0 0x0005-0x0003, req1 0x0003-0x0005) -> req0 served first (diff 0x0002, id 0), then req1 (diff 0xFFFE, borrow 1, id 1); third tie grants req0.
REQ-035 res_ready held low 5 cycles in DONE -> res_valid and all result outputs stable; requester readies low throughout; IDLE one cycle after res_ready pulse.
REQ-036 rst_n low for one cycle during RUN nibble 2 -> IDLE, res_valid never asserts for that operation, all outputs at reset values, next tie grants req0.
